dma_axi_rd_burst: RTL and testbench

Parametrised AXI4 read-DMA engine: one configuration command moves an arbitrary number of data beats from memory to an output stream. It splits the transfer into INCR bursts of at most `MAX_BEATS` beats, and no burst crosses a 4 KB boundary. `out_ready` backpressure is passed straight through to `m_axi_rready`. It sits between the DMA register/control block and the AXI interconnect, replacing the single-burst read path.

---
 rtl/dma_axi_rd_burst.sv | 174 +++++++++++++++++
 tb/tb_dma_axi_rd_burst.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_axi_rd_burst.sv
// AXI4 read DMA: one command becomes a chain of INCR bursts (<= MAX_BEATS, never
// crossing 4 KB), streamed to out_* with out_ready passed straight to rready.
module dma_axi_rd_burst #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int XFER_W    = 16,
  parameter int MAX_BEATS = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [XFER_W-1:0] cfg_beats,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic [3:0]        m_axi_arid,
  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic [7:0]        m_axi_arlen,
  output logic [2:0]        m_axi_arsize,
  output logic [1:0]        m_axi_arburst,
  output logic              m_axi_arlock,
  output logic [3:0]        m_axi_arcache,
  output logic [2:0]        m_axi_arprot,
  output logic [3:0]        m_axi_arqos,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  input  logic [DATA_W-1:0] m_axi_rdata,
  input  logic [1:0]        m_axi_rresp,
  input  logic              m_axi_rlast,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready,
  output logic [1:0]        dbg_state
);

  localparam int SZ    = $clog2(DATA_W / 8);
  localparam int BYTES = DATA_W / 8;
  localparam int CW    = (XFER_W > 13) ? XFER_W : 13;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [ADDR_W-1:0] addr_r;
  logic [XFER_W-1:0] rem_r;
  logic [8:0]        blen_r;
  logic [8:0]        beat_cnt;
  logic              error_r;

  logic [CW-1:0]     rem_w;
  logic [12:0]       rem_cap;
  logic [12:0]       room_4k;
  logic [8:0]        blen;
  logic              beat;
  logic              last_in_burst;
  logic              beat_err;

  // Burst length: remaining beats, capped by MAX_BEATS and by the room left in this 4 KB page.
  always_comb begin
    rem_w   = CW'(rem_r);
    rem_cap = (rem_w >= CW'(MAX_BEATS)) ? 13'(MAX_BEATS) : 13'(rem_w);
    room_4k = (13'd4096 - {1'b0, addr_r[11:0]}) >> SZ;
    blen    = 9'((rem_cap < room_4k) ? rem_cap : room_4k);
  end

  // valid/ready: a transfer happens on a rising edge where both are high; a source
  // holds its payload stable while valid is high and ready is low.
  assign beat          = (state == S_DATA) && m_axi_rvalid && out_ready;
  assign last_in_burst = (beat_cnt == (blen_r - 9'd1));
  assign beat_err      = (m_axi_rresp >= 2'b10) || (last_in_burst != m_axi_rlast);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      addr_r   <= '0;
      rem_r    <= '0;
      blen_r   <= '0;
      beat_cnt <= '0;
      error_r  <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE: begin
          if (cfg_valid) begin
            addr_r  <= cfg_addr & ~ADDR_W'(BYTES - 1);
            rem_r   <= cfg_beats;
            error_r <= 1'b0;
          end
        end
        S_ADDR: begin
          blen_r   <= blen;
          beat_cnt <= '0;
        end
        S_DATA: begin
          if (beat) begin
            beat_cnt <= beat_cnt + 9'd1;
            addr_r   <= addr_r + ADDR_W'(BYTES);
            if (rem_r != '0) begin
              rem_r <= rem_r - XFER_W'(1);
            end
            if (beat_err) begin
              error_r <= 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    state_nx      = state;
    cfg_ready     = 1'b0;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    out_valid     = 1'b0;
    case (state)
      S_IDLE: begin
        cfg_ready = 1'b1;
        if (cfg_valid) begin
          state_nx = (cfg_beats == '0) ? S_DONE : S_ADDR;
        end
      end
      S_ADDR: begin
        m_axi_arvalid = 1'b1;
        if (m_axi_arready) begin
          state_nx = S_DATA;
        end
      end
      S_DATA: begin
        m_axi_rready = out_ready;
        out_valid    = m_axi_rvalid;
        if (beat && last_in_burst) begin
          state_nx = (rem_r == XFER_W'(1)) ? S_DONE : S_ADDR;
        end
      end
      S_DONE: begin
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  assign busy     = (state != S_IDLE);
  assign done     = (state == S_DONE);
  assign error    = error_r;
  assign out_data = m_axi_rdata;
  assign out_last = out_valid && (rem_r == XFER_W'(1));

  assign m_axi_arid    = 4'd0;
  assign m_axi_araddr  = addr_r;
  assign m_axi_arlen   = 8'(blen - 9'd1);
  assign m_axi_arsize  = 3'(SZ);
  assign m_axi_arburst = 2'b01;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = 4'b0010;
  assign m_axi_arprot  = 3'b010;
  assign m_axi_arqos   = 4'd0;
  assign dbg_state     = state;

endmodule

// File: tb/tb_dma_axi_rd_burst.sv
// Bench for dma_axi_rd_burst: random AXI slave and stream sink, checked against
// a transfer-level model (burst list plus expected data sequence per command).
`timescale 1ns/1ps
module tb_dma_axi_rd_burst;

  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 32;
  localparam int XFER_W    = 16;
  localparam int MAX_BEATS = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [ADDR_W-1:0] cfg_addr;
  logic [XFER_W-1:0] cfg_beats;
  logic              busy;
  logic              done;
  logic              error;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic [3:0]        m_axi_arid;
  logic [ADDR_W-1:0] m_axi_araddr;
  logic [7:0]        m_axi_arlen;
  logic [2:0]        m_axi_arsize;
  logic [1:0]        m_axi_arburst;
  logic              m_axi_arlock;
  logic [3:0]        m_axi_arcache;
  logic [2:0]        m_axi_arprot;
  logic [3:0]        m_axi_arqos;
  logic              m_axi_arvalid;
  logic              m_axi_arready;
  logic [DATA_W-1:0] m_axi_rdata;
  logic [1:0]        m_axi_rresp;
  logic              m_axi_rlast;
  logic              m_axi_rvalid;
  logic              m_axi_rready;
  logic [1:0]        dbg_state;

  dma_axi_rd_burst #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .XFER_W(XFER_W), .MAX_BEATS(MAX_BEATS)
  ) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_addr(cfg_addr), .cfg_beats(cfg_beats),
    .busy(busy), .done(done), .error(error),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
    .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot), .m_axi_arqos(m_axi_arqos),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  logic [DATA_W-1:0] exp_q[$];
  logic [39:0]       burst_q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // Transfer-level model: the expected beat data and the list of (address, arlen) bursts.
  task automatic build_model(input logic [31:0] addr, input int beats);
    logic [31:0] a;
    int r, b, room;
    a = addr & 32'hFFFF_FFFC;
    r = beats;
    for (int i = 0; i < beats; i++) exp_q.push_back(mem_word(a + 32'(4 * i)));
    while (r > 0) begin
      room = (4096 - int'(a % 4096)) / 4;
      b = (r < MAX_BEATS) ? r : MAX_BEATS;
      if (b > room) b = room;
      burst_q.push_back({a, 8'(b - 1)});
      a = a + 32'(4 * b);
      r = r - b;
    end
  endtask

  // ---------------- AXI slave + stream sink + monitor ----------------
  int          gbeat = 0;
  int          inj_resp = -1;
  int          inj_rlast = -1;
  bit          rand_ready = 1'b0;
  int unsigned last_beat_cyc = 0;

  initial begin : slave
    bit          ar_hs, r_hs, cfg_hs, phase;
    logic [31:0] ar_addr_s, sl_addr;
    logic [7:0]  ar_len_s;
    logic [39:0] b;
    int          sl_len, sl_idx;
    ar_hs = 0; r_hs = 0; cfg_hs = 0; phase = 0;
    ar_addr_s = '0; ar_len_s = '0; sl_addr = '0; sl_len = 0; sl_idx = 0;
    m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rdata = '0;
    m_axi_rresp = 2'b00; m_axi_rlast = 1'b0; out_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        phase = 0; ar_hs = 0; r_hs = 0; cfg_hs = 0;
        m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; out_ready = 1'b0;
      end else begin
        if (cfg_hs) gbeat = 0;
        if (ar_hs) begin
          chk("ar_expected", burst_q.size() != 0, 1);
          if (burst_q.size() != 0) begin
            b = burst_q.pop_front();
            chk("araddr", ar_addr_s, b[39:8]);
            chk("arlen", ar_len_s, b[7:0]);
          end
          phase = 1; sl_addr = ar_addr_s; sl_len = int'(ar_len_s); sl_idx = 0;
        end
        if (r_hs) begin
          sl_idx++;
          sl_addr += 4;
          gbeat++;
          if (sl_idx > sl_len) phase = 0;
        end
        m_axi_arready = ($urandom_range(0, 2) != 0);
        if (phase) begin
          if (!m_axi_rvalid || r_hs) m_axi_rvalid = ($urandom_range(0, 3) != 0);
          m_axi_rdata = mem_word(sl_addr);
          m_axi_rlast = (sl_idx == sl_len) ^ (gbeat == inj_rlast);
          m_axi_rresp = (gbeat == inj_resp) ? 2'b10 : 2'b00;
        end else begin
          m_axi_rvalid = 1'b0;
        end
        out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        #1;
        cfg_hs    = cfg_valid && cfg_ready;
        ar_hs     = m_axi_arvalid && m_axi_arready;
        ar_addr_s = m_axi_araddr;
        ar_len_s  = m_axi_arlen;
        r_hs      = m_axi_rvalid && m_axi_rready;
        if (ar_hs) begin
          chk("arsize", m_axi_arsize, 3'd2);
          chk("arburst", m_axi_arburst, 2'b01);
        end
        chk("rready", m_axi_rready, phase ? out_ready : 1'b0);
        chk("out_valid", out_valid, phase ? m_axi_rvalid : 1'b0);
        if (out_valid && out_ready) begin
          chk("beat_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            chk("out_data", out_data, exp_q[0]);
            chk("out_last", out_last, exp_q.size() == 1);
            void'(exp_q.pop_front());
          end
          last_beat_cyc = cyc;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue_cfg(input logic [31:0] addr, input int beats);
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!cfg_ready && t < 2000);
    chk("cfg_ready_idle", cfg_ready, 1);
    cfg_valid = 1'b1;
    cfg_addr  = addr;
    cfg_beats = XFER_W'(beats);
    @(negedge clk);
    cfg_valid = 1'b0;
    cfg_addr  = $urandom;
    cfg_beats = XFER_W'($urandom);
    #2;
  endtask

  task automatic run_cmd(input logic [31:0] addr, input int beats, input bit exp_err, input bit junk);
    int t;
    build_model(addr, beats);
    issue_cfg(addr, beats);
    if (beats == 0) begin
      chk("zero_done_n1", done, 1);
      chk("zero_arvalid", m_axi_arvalid, 0);
      chk("zero_error", error, exp_err);
      @(negedge clk); #2;
      chk("zero_done_pulse", done, 0);
      chk("zero_cfg_ready", cfg_ready, 1);
    end else begin
      chk("arvalid_n1", m_axi_arvalid, 1);
      chk("busy", busy, 1);
      chk("error_cleared", error, 0);
      t = 0;
      while (!done && t < 3000) begin
        @(negedge clk);
        if (junk) begin
          cfg_valid = 1'($urandom_range(0, 1));
          cfg_beats = XFER_W'($urandom_range(0, 3));
        end
        #2;
        t++;
      end
      cfg_valid = 1'b0;
      chk("done_seen", done, 1);
      chk("done_latency", cyc, last_beat_cyc + 1);
      chk("error_at_done", error, exp_err);
      chk("cfg_ready_in_done", cfg_ready, 0);
      chk("beats_left", exp_q.size(), 0);
      chk("bursts_left", burst_q.size(), 0);
      @(negedge clk); #2;
      chk("done_pulse", done, 0);
      chk("cfg_ready_after", cfg_ready, 1);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cfg_ready"}, cfg_ready, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_error"}, error, 0);
    chk({tag, "_arvalid"}, m_axi_arvalid, 0);
    chk({tag, "_rready"}, m_axi_rready, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_last"}, out_last, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    logic [31:0] a;
    int n, t;
    rst = 1'b1; cfg_valid = 1'b0; cfg_addr = '0; cfg_beats = '0;
    repeat (3) @(negedge clk);
    #2;
    check_reset_outputs("reset");
    rst = 1'b0;

    rand_ready = 1'b0;
    run_cmd(32'h0000_0100, 4, 1'b0, 1'b0);
    run_cmd(32'h0000_0000, 40, 1'b0, 1'b0);
    run_cmd(32'h0000_0FF8, 10, 1'b0, 1'b0);
    rand_ready = 1'b1;
    run_cmd(32'h0000_2000, 40, 1'b0, 1'b1);

    inj_resp = 2;
    run_cmd(32'h0000_0300, 6, 1'b1, 1'b0);
    inj_resp  = -1;
    inj_rlast = 1;
    run_cmd(32'h0000_0400, 4, 1'b1, 1'b0);
    inj_rlast = -1;
    run_cmd(32'h0000_0500, 3, 1'b0, 1'b0);

    run_cmd(32'h0000_0600, 0, 1'b0, 1'b0);
    run_cmd(32'h0000_0123, 5, 1'b0, 1'b0);

    // reset in the middle of a data phase
    build_model(32'h0000_3000, 40);
    issue_cfg(32'h0000_3000, 40);
    t = 0;
    while (gbeat < 5 && t < 2000) begin
      @(negedge clk); #2;
      t++;
    end
    chk("reset_reached_data", gbeat >= 5, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("midrst");
    @(negedge clk); #2;
    exp_q.delete();
    burst_q.delete();
    rst = 1'b0;
    run_cmd(32'h0000_3000, 5, 1'b0, 1'b0);

    for (int i = 0; i < 10; i++) begin
      if ($urandom_range(0, 1) == 1)
        a = 32'(4096 * $urandom_range(1, 8)) - 32'(4 * $urandom_range(0, 24)) + 32'($urandom_range(0, 3));
      else
        a = 32'($urandom_range(0, 32'h0000_FFFF));
      n = $urandom_range(0, 50);
      rand_ready = 1'($urandom_range(0, 1));
      run_cmd(a, n, 1'b0, 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
